// File: rtl/spi_responder.sv
// spi_responder: SPI mode-3 peripheral with a small byte-wide register file.
//
// A frame is one command byte (bit7 = read, bits6:0 = start address)
// followed by any number of data bytes. The address auto-increments
// (7-bit wrap) after every complete data byte. SPC, CS and SDI are
// oversampled in the clk domain through 2-flop synchronizers. A host port
// gives direct register access alongside the SPI side.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   SPC, CS, SDI         SPI clock (idles high), chip select (active low), data in
//   SDO                  SPI data out, 0 when not driving
//   host_we/addr/wdata   host write strobe, address, data
//   host_rdata           registered read of reg[host_addr]
//   wr_valid/addr/data   one-clk pulse describing each committed SPI write
//   busy                 high while a frame is in progress
module spi_responder #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [6:0]  WHO_ADDR = 7'h0F,
    parameter logic [7:0]  WHO_VAL  = 8'h33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SPC,
    input  logic       CS,
    input  logic       SDI,
    output logic       SDO,
    input  logic       host_we,
    input  logic [6:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Synchronizer stages plus previous synced value for edge detection
    logic spc_meta_q, spc_sync_q, spc_prev_q;
    logic cs_meta_q,  cs_sync_q,  cs_prev_q;
    logic sdi_meta_q, sdi_sync_q;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] addr_q, addr_d;
    logic       rnw_q, rnw_d;
    logic       sdo_q, sdo_d;
    logic       busy_q, busy_d;
    logic       wr_valid_q;
    logic [6:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic [7:0] host_rdata_q;
    logic [7:0] regs_q [DEPTH];

    logic       spc_rise_c, spc_fall_c, cs_fall_c;
    logic [7:0] rx_byte_c;
    logic [6:0] rd_addr_c;
    logic [7:0] rd_val_c;
    logic [7:0] host_val_c;
    logic       spi_we_c;
    logic       host_we_ok_c;

    function automatic logic in_range(input logic [6:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic writable(input logic [6:0] a);
        return (a != WHO_ADDR) && in_range(a);
    endfunction

    // Identity register shadows the file; unimplemented addresses read as zero
    function automatic logic [7:0] lookup(input logic [6:0] a);
        if (a == WHO_ADDR) begin
            return WHO_VAL;
        end else if (in_range(a)) begin
            return regs_q[a[AW-1:0]];
        end else begin
            return 8'h00;
        end
    endfunction

    assign spc_rise_c   = spc_sync_q & ~spc_prev_q;
    assign spc_fall_c   = ~spc_sync_q & spc_prev_q;
    assign cs_fall_c    = ~cs_sync_q & cs_prev_q;
    assign rx_byte_c    = {rx_q, sdi_sync_q};
    // In CMD the address being completed is the low 7 bits of the incoming byte
    assign rd_addr_c    = (state_q == CMD) ? rx_byte_c[6:0] : addr_q;
    assign rd_val_c     = lookup(rd_addr_c);
    assign host_val_c   = lookup(host_addr);
    assign host_we_ok_c = host_we & writable(host_addr);

    // Next-state and frame datapath
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        rnw_d     = rnw_q;
        sdo_d     = sdo_q;
        spi_we_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall_c) begin
                    state_d   = CMD;
                    bit_cnt_d = 3'd0;
                    sdo_d     = 1'b0;
                end
            end
            CMD: begin
                if (cs_sync_q) begin
                    state_d = IDLE;
                    sdo_d   = 1'b0;
                end else if (spc_rise_c) begin
                    rx_d      = rx_byte_c[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = DATA;
                        rnw_d   = rx_byte_c[7];
                        addr_d  = rx_byte_c[6:0];
                        if (rx_byte_c[7]) begin
                            tx_d   = rd_val_c;
                            addr_d = rx_byte_c[6:0] + 7'd1;
                        end
                    end
                end
            end
            DATA: begin
                if (cs_sync_q) begin
                    state_d = IDLE;
                    sdo_d   = 1'b0;
                end else if (spc_rise_c) begin
                    rx_d      = rx_byte_c[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d = addr_q + 7'd1;
                        if (rnw_q) begin
                            tx_d = rd_val_c;
                        end else if (writable(addr_q)) begin
                            spi_we_c = 1'b1;
                        end
                    end
                end else if (spc_fall_c && rnw_q) begin
                    sdo_d = tx_q[7];
                    tx_d  = {tx_q[6:0], 1'b0};
                end
            end
            default: begin
                state_d = IDLE;
                sdo_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Synchronizers, FSM state and registered outputs.
    // CS synchronizer resets low so a frame already in progress when reset
    // drops is ignored until CS has risen and fallen again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spc_meta_q   <= 1'b1;
            spc_sync_q   <= 1'b1;
            spc_prev_q   <= 1'b1;
            cs_meta_q    <= 1'b0;
            cs_sync_q    <= 1'b0;
            cs_prev_q    <= 1'b0;
            sdi_meta_q   <= 1'b0;
            sdi_sync_q   <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 7'd0;
            tx_q         <= 8'd0;
            addr_q       <= 7'd0;
            rnw_q        <= 1'b0;
            sdo_q        <= 1'b0;
            busy_q       <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= 7'd0;
            wr_data_q    <= 8'd0;
            host_rdata_q <= 8'd0;
        end else begin
            spc_meta_q   <= SPC;
            spc_sync_q   <= spc_meta_q;
            spc_prev_q   <= spc_sync_q;
            cs_meta_q    <= CS;
            cs_sync_q    <= cs_meta_q;
            cs_prev_q    <= cs_sync_q;
            sdi_meta_q   <= SDI;
            sdi_sync_q   <= sdi_meta_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            rnw_q        <= rnw_d;
            sdo_q        <= sdo_d;
            busy_q       <= busy_d;
            wr_valid_q   <= spi_we_c;
            host_rdata_q <= host_val_c;
            if (spi_we_c) begin
                wr_addr_q <= addr_q;
                wr_data_q <= rx_byte_c;
            end
        end
    end

    // Register file; an SPI commit takes priority over a host write to the same entry
    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                regs_q[g] <= 8'h00;
            end else if (spi_we_c && (addr_q == 7'(g))) begin
                regs_q[g] <= rx_byte_c;
            end else if (host_we_ok_c && (host_addr == 7'(g))) begin
                regs_q[g] <= host_wdata;
            end
        end
    end

    assign SDO        = sdo_q;
    assign busy       = busy_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = host_rdata_q;

endmodule
